// File: rtl/i2c_slave_fsm.sv
// I2C target: oversamples scl/sda in the clk domain, detects START/STOP, matches a
// 7-bit address, ACKs write bytes onto rx_data and serves read bytes from tx_data.
module i2c_slave_fsm #(
  parameter int                  ADDR_LEN    = 7,
  parameter int                  DATA_LEN    = 8,
  parameter logic [ADDR_LEN-1:0] SLAVE_ADDR  = 7'b1010110,
  parameter int                  SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scl,
  input  logic                sda_in,
  output logic                sda_oe,
  input  logic [DATA_LEN-1:0] tx_data,
  output logic                tx_req,
  output logic [DATA_LEN-1:0] rx_data,
  output logic                rx_valid,
  output logic                rw,
  output logic                addr_match,
  output logic                busy
);

  localparam int SH_W = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic [SH_W-1:0]        shifter;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_s, sda_s, scl_d, sda_d;
  logic                   scl_rise, scl_fall, start_c, stop_c;

  // Synchronisers reset to the idle-bus level so release of reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start_c  = scl_s & sda_d & ~sda_s;
  assign stop_c   = scl_s & ~sda_d & sda_s;

  function automatic logic [3:0] inc_sat(input logic [3:0] c);
    return (c >= 4'd8) ? 4'd8 : c + 4'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shifter    <= '0;
      sda_oe     <= 1'b0;
      tx_req     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rw         <= 1'b0;
      addr_match <= 1'b0;
      busy       <= 1'b0;
    end else begin
      tx_req   <= 1'b0;
      rx_valid <= 1'b0;
      if (start_c) begin
        state      <= ADDR;
        cnt        <= '0;
        sda_oe     <= 1'b0;
        addr_match <= 1'b0;
        busy       <= 1'b1;
      end else if (stop_c) begin
        state      <= IDLE;
        cnt        <= '0;
        sda_oe     <= 1'b0;
        addr_match <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: if (scl_rise) begin
            shifter <= {shifter[SH_W-2:0], sda_s};
            cnt     <= inc_sat(cnt);
            // Last rise carries R/W; shifter still holds just the address bits.
            if (cnt == 4'(ADDR_LEN)) begin
              rw    <= sda_s;
              cnt   <= '0;
              state <= (shifter[ADDR_LEN-1:0] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
            end
          end
          ADDR_ACK, WR_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe     <= 1'b1;
              addr_match <= 1'b1;
            end else if (state == WR_ACK || !rw) begin
              sda_oe <= 1'b0;
              cnt    <= '0;
              state  <= WR_DATA;
            end else begin
              tx_req  <= 1'b1;
              shifter <= SH_W'(tx_data);
              sda_oe  <= ~tx_data[DATA_LEN-1];
              cnt     <= '0;
              state   <= RD_DATA;
            end
          end
          WR_DATA: if (scl_rise) begin
            shifter <= {shifter[SH_W-2:0], sda_s};
            cnt     <= inc_sat(cnt);
            if (cnt == 4'(DATA_LEN-1)) begin
              rx_data  <= {shifter[DATA_LEN-2:0], sda_s};
              rx_valid <= 1'b1;
              cnt      <= '0;
              state    <= WR_ACK;
            end
          end
          RD_DATA: if (scl_fall) begin
            if (cnt == 4'(DATA_LEN-1)) begin
              sda_oe <= 1'b0;
              cnt    <= '0;
              state  <= RD_ACK;
            end else begin
              cnt     <= inc_sat(cnt);
              shifter <= {shifter[SH_W-2:0], 1'b0};
              sda_oe  <= ~shifter[DATA_LEN-2];
            end
          end
          // cnt==8 marks a master ACK seen on the rise; the following fall reloads.
          RD_ACK: begin
            if (scl_rise) begin
              if (sda_s) state <= WAIT_STOP;
              else       cnt   <= 4'd8;
            end else if (scl_fall && cnt == 4'd8) begin
              tx_req  <= 1'b1;
              shifter <= SH_W'(tx_data);
              sda_oe  <= ~tx_data[DATA_LEN-1];
              cnt     <= '0;
              state   <= RD_DATA;
            end
          end
          WAIT_STOP: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_fsm.sv
// Directed bench for i2c_slave_fsm: a bit-level master model drives scl/sda and a
// negedge monitor tallies rx_valid/tx_req/sda_oe/addr_match activity.
module tb_i2c_slave_fsm;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst_n, scl, sda_m, sda_in, sda_oe;
  logic [7:0] tx_data, rx_data;
  logic       tx_req, rx_valid, rw, addr_match, busy;

  int n_chk = 0, n_fail = 0;
  int rxv_cnt = 0, tx_cnt = 0, oe_cnt = 0, am_cnt = 0;
  logic [7:0] rx_last = 8'h00, rx_prev = 8'h00;

  assign sda_in = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_slave_fsm dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda_in(sda_in), .sda_oe(sda_oe),
    .tx_data(tx_data), .tx_req(tx_req), .rx_data(rx_data), .rx_valid(rx_valid),
    .rw(rw), .addr_match(addr_match), .busy(busy)
  );

  function automatic logic [7:0] tx_tbl(input int i);
    case (i)
      0:       return 8'hC3;
      1:       return 8'h5A;
      2:       return 8'h96;
      default: return 8'h00;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rx_valid) begin
      rxv_cnt = rxv_cnt + 1;
      rx_prev = rx_last;
      rx_last = rx_data;
    end
    if (tx_req) tx_cnt = tx_cnt + 1;
    if (sda_oe) oe_cnt = oe_cnt + 1;
    if (addr_match) am_cnt = am_cnt + 1;
    tx_data = tx_tbl(tx_cnt);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_cond();
    wait_clk(H/2); sda_m = 1'b1;
    wait_clk(H/2); scl = 1'b1;
    wait_clk(H);   sda_m = 1'b0;
    wait_clk(H);   scl = 1'b0;
  endtask

  task automatic stop_cond();
    wait_clk(H/2); sda_m = 1'b0;
    wait_clk(H/2); scl = 1'b1;
    wait_clk(H);   sda_m = 1'b1;
    wait_clk(H);
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    wait_clk(H/2); sda_m = b;
    wait_clk(H/2); scl = 1'b1;
    wait_clk(H);   r = sda_in; scl = 1'b0;
  endtask

  task automatic byte_w(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) xfer_bit(d[i], r);
    xfer_bit(1'b1, ack);
  endtask

  task automatic byte_r(input logic mack, output logic [7:0] d, output logic ackbit);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, r);
      d[i] = r;
    end
    xfer_bit(mack, ackbit);
  endtask

  logic       a0, a1, a2, r;
  logic [7:0] d0, d1;
  int         base_rx, base_tx, base_oe, base_am;

  initial begin
    rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1;
    wait_clk(3);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_outs", {tx_req, rx_valid, rw, addr_match}, 4'b0000);
    rst_n = 1'b1;
    wait_clk(4);

    // 1: write two bytes
    base_rx = rxv_cnt;
    start_cond();
    check("t1_busy_start", busy, 1);
    byte_w(8'hAC, a0);
    byte_w(8'hA5, a1);
    byte_w(8'h3C, a2);
    check("t1_acks", {a0, a1, a2}, 3'b000);
    check("t1_rxv_cnt", rxv_cnt - base_rx, 2);
    check("t1_rx_first", rx_prev, 8'hA5);
    check("t1_rx_second", rx_last, 8'h3C);
    check("t1_rw", rw, 0);
    check("t1_busy_pre_stop", busy, 1);
    stop_cond();
    check("t1_busy_post_stop", busy, 0);
    check("t1_am_post_stop", addr_match, 0);

    // 2: foreign address
    base_rx = rxv_cnt; base_oe = oe_cnt; base_am = am_cnt;
    start_cond();
    byte_w(8'h56, a0);
    byte_w(8'h00, a1);
    check("t2_nack", {a0, a1}, 2'b11);
    check("t2_busy", busy, 1);
    stop_cond();
    check("t2_oe_cycles", oe_cnt - base_oe, 0);
    check("t2_am_cycles", am_cnt - base_am, 0);
    check("t2_rxv", rxv_cnt - base_rx, 0);
    check("t2_busy_stop", busy, 0);

    // 3: read 0xC3 (ACK) then 0x5A (NACK)
    base_tx = tx_cnt;
    start_cond();
    byte_w(8'hAD, a0);
    check("t3_addr_ack", a0, 0);
    check("t3_rw", rw, 1);
    byte_r(1'b0, d0, a1);
    byte_r(1'b1, d1, a2);
    check("t3_byte0", d0, 8'hC3);
    check("t3_byte1", d1, 8'h5A);
    check("t3_nack_seen", a2, 1);
    check("t3_tx_req", tx_cnt - base_tx, 2);
    wait_clk(H);
    check("t3_oe_after_nack", sda_oe, 0);
    stop_cond();

    // 4: write 0x11, repeated START, read 0x96
    base_rx = rxv_cnt;
    start_cond();
    byte_w(8'hAC, a0);
    byte_w(8'h11, a1);
    check("t4_am_write", addr_match, 1);
    start_cond();
    check("t4_am_rstart", addr_match, 0);
    byte_w(8'hAD, a2);
    check("t4_acks", {a0, a1, a2}, 3'b000);
    check("t4_am_read", addr_match, 1);
    check("t4_rw", rw, 1);
    byte_r(1'b1, d0, r);
    check("t4_read", d0, 8'h96);
    stop_cond();
    check("t4_rxv", rxv_cnt - base_rx, 1);
    check("t4_rx_data", rx_data, 8'h11);

    // 5: STOP after 3 data bits
    base_rx = rxv_cnt;
    start_cond();
    byte_w(8'hAC, a0);
    xfer_bit(1'b1, r); xfer_bit(1'b0, r); xfer_bit(1'b1, r);
    stop_cond();
    check("t5_rxv", rxv_cnt - base_rx, 0);
    check("t5_rx_keep", rx_data, 8'h11);
    check("t5_idle", {busy, addr_match, sda_oe}, 3'b000);

    // 6: async reset during the address ACK
    start_cond();
    for (int i = 7; i >= 0; i--) xfer_bit(i == 0 ? 1'b0 : (8'hAC >> i) & 1'b1, r);
    for (int k = 0; k < 20 && !sda_oe; k++) @(negedge clk);
    check("t6_oe_ack", sda_oe, 1);
    #1 rst_n = 1'b0;
    #1 check("t6_oe_async", sda_oe, 0);
    check("t6_outs", {busy, addr_match, rw, tx_req, rx_valid}, 5'b00000);
    check("t6_rx_data", rx_data, 8'h00);
    sda_m = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(2);
    scl = 1'b1;
    wait_clk(H);
    base_rx = rxv_cnt;
    start_cond();
    byte_w(8'hAC, a0);
    byte_w(8'h77, a1);
    stop_cond();
    check("t6_acks", {a0, a1}, 2'b00);
    check("t6_rxv", rxv_cnt - base_rx, 1);
    check("t6_rx_data_new", rx_last, 8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
